// File: rtl/aes_key_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the AES-128 key schedule controller.
package aes_key_pkg;

  localparam int N_ROUND_DEF = 10;
  localparam int WORD_W      = 32;
  localparam int KEY_W       = 4 * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXPAND = 2'b01,
    ST_DONE   = 2'b10
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (aa & {8{b[i]}});
      aa  = xtime(aa);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fn(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_round_step.sv
// One combinational AES-128 key expansion round, plus the byte S-box it uses.
module aes_sbox
  import aes_key_pkg::*;
(
  input  logic [7:0] in_byte_i,
  output logic [7:0] out_byte_o
);
  assign out_byte_o = sbox_fn(in_byte_i);
endmodule

module key_round_step
  import aes_key_pkg::*;
(
  input  logic [0:KEY_W-1] prev_key_i,
  input  logic [7:0]       rcon_i,
  output logic [0:KEY_W-1] next_key_o
);
  logic [WORD_W-1:0] pw0_s, pw1_s, pw2_s, pw3_s;
  logic [WORD_W-1:0] rot_s, sub_s;
  logic [WORD_W-1:0] nw0_s, nw1_s, nw2_s, nw3_s;

  assign pw0_s = prev_key_i[0:31];
  assign pw1_s = prev_key_i[32:63];
  assign pw2_s = prev_key_i[64:95];
  assign pw3_s = prev_key_i[96:127];
  assign rot_s = {pw3_s[23:0], pw3_s[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte_i (rot_s[8*b +: 8]),
      .out_byte_o(sub_s[8*b +: 8])
    );
  end

  assign nw0_s      = pw0_s ^ sub_s ^ {rcon_i, 24'h000000};
  assign nw1_s      = nw0_s ^ pw1_s;
  assign nw2_s      = nw1_s ^ pw2_s;
  assign nw3_s      = nw2_s ^ pw3_s;
  assign next_key_o = {nw0_s, nw1_s, nw2_s, nw3_s};
endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key schedule: expands one round key per cycle into a slot
// array and serves registered round-key reads.
module key_schedule_ctrl
  import aes_key_pkg::*;
#(
  parameter int N_ROUND = N_ROUND_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [0:127]   key_in,
  input  logic           start,
  output logic           ready,
  output logic           busy,
  output logic           keys_valid,
  input  logic           rd_en,
  input  logic [3:0]     rd_idx,
  output logic [0:127]   rd_data,
  output logic           rd_valid,
  output logic           rd_err
);
  ks_state_e      state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           keys_valid_q, keys_valid_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_err_q, rd_err_d;
  logic [0:127]   rd_data_q, rd_data_d;

  logic [0:127]   slots_q [0:N_ROUND];
  logic           wr_en_s;
  logic [3:0]     wr_idx_s;
  logic [0:127]   wr_data_s;
  logic [0:127]   step_out_s;

  key_round_step u_step (
    .prev_key_i(slots_q[cnt_q - 4'd1]),
    .rcon_i    (rcon_q),
    .next_key_o(step_out_s)
  );

  // FSM next state, round counter, rcon and slot write control.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rcon_d       = rcon_q;
    keys_valid_d = keys_valid_q;
    wr_en_s      = 1'b0;
    wr_idx_s     = 4'd0;
    wr_data_s    = key_in;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_EXPAND;
          cnt_d        = 4'd1;
          rcon_d       = 8'h01;
          keys_valid_d = 1'b0;
          wr_en_s      = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_EXPAND: begin
        wr_en_s   = 1'b1;
        wr_idx_s  = cnt_q;
        wr_data_s = step_out_s;
        rcon_d    = xtime(rcon_q);
        if (cnt_q == 4'(N_ROUND)) begin
          state_d      = ST_DONE;
          keys_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        keys_valid_d = 1'b0;
      end
    endcase
  end

  // Reads are judged against keys_valid before this edge, so a read that
  // coincides with a restart still returns the old slot contents.
  always_comb begin
    rd_valid_d = rd_en;
    rd_err_d   = 1'b0;
    rd_data_d  = '0;
    if (rd_en) begin
      if ((rd_idx > 4'(N_ROUND)) || !keys_valid_q) begin
        rd_err_d = 1'b1;
      end else begin
        rd_data_d = slots_q[rd_idx];
      end
    end else begin
      rd_err_d = 1'b0;
    end
  end

  // Control and read-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      rcon_q       <= 8'h00;
      keys_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcon_q       <= rcon_d;
      keys_valid_q <= keys_valid_d;
      rd_valid_q   <= rd_valid_d;
      rd_err_q     <= rd_err_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Key storage is deliberately left out of reset; keys_valid gates access.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      slots_q[wr_idx_s] <= wr_data_s;
    end
  end

  assign ready      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy       = (state_q == ST_EXPAND);
  assign keys_valid = keys_valid_q;
  assign rd_valid   = rd_valid_q;
  assign rd_err     = rd_err_q;
  assign rd_data    = rd_data_q;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed plus random checks of key_schedule_ctrl against a FIPS-197 style
// word-by-word key expansion model built from first principles.
module tb_key_schedule_ctrl;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:127] key_in;
  logic         start;
  logic         ready, busy, keys_valid;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [0:127] rd_data;
  logic         rd_valid, rd_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] exp_keys [0:NR];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_schedule_ctrl #(.N_ROUND(NR)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .start(start),
    .ready(ready), .busy(busy), .keys_valid(keys_valid),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // Polynomial product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 8'h00;
      sbox_tab[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 4*NR+4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = ref_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_exp(input logic [127:0] key, input string tag);
    key_in = key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check({tag, "_busy_e0"}, 128'(busy), 128'd1);
    check({tag, "_kv_e0"}, 128'(keys_valid), 128'd0);
    check({tag, "_ready_e0"}, 128'(ready), 128'd0);
  endtask

  task automatic wait_done(input int first, input string tag);
    for (int c = first; c <= NR; c++) begin
      tick();
      if (c == NR - 1) check({tag, "_kv_early"}, 128'(keys_valid), 128'd0);
    end
    check({tag, "_kv_done"}, 128'(keys_valid), 128'd1);
    check({tag, "_busy_done"}, 128'(busy), 128'd0);
    check({tag, "_ready_done"}, 128'(ready), 128'd1);
  endtask

  task automatic read_one(input logic [3:0] idx, input logic exp_err,
                          input logic [127:0] exp_data, input string tag);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick();
    rd_en  = 1'b0;
    check({tag, "_vld"}, 128'(rd_valid), 128'd1);
    check({tag, "_err"}, 128'(rd_err), 128'(exp_err));
    check({tag, "_data"}, rd_data, exp_data);
  endtask

  task automatic read_all(input string tag);
    rd_en = 1'b1;
    for (int i = 0; i <= NR; i++) begin
      rd_idx = 4'(i);
      tick();
      check($sformatf("%s_slot%0d", tag, i), rd_data, exp_keys[i]);
      check($sformatf("%s_err%0d", tag, i), 128'({rd_valid, rd_err}), 128'd2);
    end
    rd_en = 1'b0;
    tick();
    check({tag, "_vld_drop"}, 128'(rd_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] rkey;
    logic [3:0]   ridx;
    build_sbox();
    rst_n = 1'b0; start = 1'b0; key_in = '0; rd_en = 1'b0; rd_idx = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_kv", 128'(keys_valid), 128'd0);
    check("rst_rd", 128'({rd_valid, rd_err}), 128'd0);
    check("rst_rdata", rd_data, 128'd0);
    rst_n = 1'b1;
    tick();
    read_one(4'd0, 1'b1, 128'd0, "rd_idle");

    // FIPS-197 vector.
    model_expand(FIPS_KEY);
    start_exp(FIPS_KEY, "fips");
    wait_done(1, "fips");
    read_all("fips");
    read_one(4'd1, 1'b0, FIPS_R1, "fips_r1_const");
    read_one(4'd10, 1'b0, FIPS_R10, "fips_r10_const");
    read_one(4'd11, 1'b1, 128'd0, "rd_idx11");
    read_one(4'd15, 1'b1, 128'd0, "rd_idx15");

    // All-zero key, restarted from DONE.
    model_expand(128'd0);
    start_exp(128'd0, "zero");
    read_one(4'd2, 1'b1, 128'd0, "rd_busy");
    wait_done(2, "zero");
    read_all("zero");
    read_one(4'd1, 1'b0, ZERO_R1, "zero_r1_const");
    read_one(4'd10, 1'b0, ZERO_R10, "zero_r10_const");

    // Restart attempt during expansion must be ignored.
    model_expand(FIPS_KEY);
    start_exp(FIPS_KEY, "ign");
    for (int c = 1; c <= NR; c++) begin
      if (c == 3) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      start  = 1'b0;
      key_in = FIPS_KEY;
      if (c == 3) check("ign_busy_e3", 128'(busy), 128'd1);
      if (c == NR - 1) check("ign_kv_early", 128'(keys_valid), 128'd0);
    end
    check("ign_kv_done", 128'(keys_valid), 128'd1);
    read_all("ign");

    // Reset in the middle of an expansion.
    start_exp(128'd0, "rst");
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 128'(busy), 128'd0);
    check("rst_mid_kv", 128'(keys_valid), 128'd0);
    check("rst_mid_ready", 128'(ready), 128'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_stay_idle", 128'({busy, keys_valid}), 128'd0);
    read_one(4'd3, 1'b1, 128'd0, "rd_after_rst");
    start_exp(FIPS_KEY, "rerun");
    wait_done(1, "rerun");
    read_all("rerun");

    // Read coinciding with a restart returns the pre-restart slot.
    rd_en = 1'b1; rd_idx = 4'd10; start = 1'b1; key_in = '0;
    tick();
    rd_en = 1'b0; start = 1'b0;
    check("coll_data", rd_data, FIPS_R10);
    check("coll_err", 128'({rd_valid, rd_err}), 128'd2);
    check("coll_busy", 128'(busy), 128'd1);
    wait_done(1, "coll");
    read_one(4'd10, 1'b0, ZERO_R10, "coll_new_r10");

    // Random keys, random read indices.
    for (int k = 0; k < 4; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      model_expand(rkey);
      start_exp(rkey, $sformatf("rnd%0d", k));
      wait_done(1, $sformatf("rnd%0d", k));
      for (int j = 0; j < 12; j++) begin
        ridx = 4'($urandom_range(0, 15));
        if (ridx > 4'(NR)) read_one(ridx, 1'b1, 128'd0, $sformatf("rnd%0d_i%0d", k, ridx));
        else read_one(ridx, 1'b0, exp_keys[ridx], $sformatf("rnd%0d_i%0d", k, ridx));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
